// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with a registered one-hot grant and a valid/ready handshake.
// The grant is held while the consumer stalls. The pointer moves only when a grant
// is accepted. Two search implementations are selectable and produce identical
// results on every cycle.
module arb_rr_oht #(
   parameter int unsigned WIDTH          = 9,
   parameter int unsigned IMPLEMENTATION = 0,
   localparam int unsigned IdxW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic [IdxW-1:0]  idx,
   output logic             vld,
   input  logic             rdy
);

   localparam int NReq = int'(WIDTH);

   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic             vld_q, vld_d;

   logic             xfer;
   logic             advance;
   logic [IdxW-1:0]  base_ptr;
   logic [IdxW-1:0]  win_idx;
   logic             win_vld;

   assign xfer    = vld_q & rdy;
   assign advance = ~vld_q | rdy;
   // On a transfer the winner just accepted becomes lowest priority in the same cycle.
   assign base_ptr = xfer ? idx_q : ptr_q;

   if (IMPLEMENTATION == 0) begin : g_masked
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] req_masked;

      // Mask off requesters at or below the base pointer.
      always_comb begin
         mask = '0;
         for (int i = 0; i < NReq; i++) begin
            mask[i] = (i > int'(base_ptr));
         end
      end

      assign req_masked = req & mask;

      // Two lowest-index priority encoders; the masked one wins if it found anything.
      always_comb begin
         logic            m_found;
         logic            u_found;
         logic [IdxW-1:0] m_idx;
         logic [IdxW-1:0] u_idx;
         m_found = 1'b0;
         u_found = 1'b0;
         m_idx   = '0;
         u_idx   = '0;
         for (int i = NReq - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
               m_found = 1'b1;
               m_idx   = IdxW'(i);
            end
            if (req[i]) begin
               u_found = 1'b1;
               u_idx   = IdxW'(i);
            end
         end
         win_vld = u_found;
         win_idx = m_found ? m_idx : u_idx;
      end
   end else begin : g_rotate
      logic [WIDTH-1:0] req_rot;
      int               start;

      assign start = (int'(base_ptr) >= NReq - 1) ? 0 : int'(base_ptr) + 1;

      // Rotate so the highest-priority requester sits at bit 0.
      always_comb begin
         req_rot = '0;
         for (int k = 0; k < NReq; k++) begin
            req_rot[k] = req[(start + k) % NReq];
         end
      end

      // Fixed-priority pick on the rotated vector, then rotate the index back.
      always_comb begin
         win_vld = 1'b0;
         win_idx = '0;
         for (int k = NReq - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
               win_vld = 1'b1;
               win_idx = IdxW'((start + k) % NReq);
            end
         end
      end
   end

   // Next state: re-arbitrate when idle or on accept, otherwise hold the grant.
   always_comb begin
      gnt_d = gnt_q;
      idx_d = idx_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      if (advance) begin
         gnt_d = win_vld ? (WIDTH'(1) << win_idx) : '0;
         idx_d = win_vld ? win_idx : '0;
         vld_d = win_vld;
      end
      if (xfer) begin
         ptr_d = idx_q;
      end
   end

   // State registers with synchronous reset; the pointer resets so index 0 wins next.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
         ptr_q <= IdxW'(WIDTH - 1);
      end else begin
         gnt_q <= gnt_d;
         idx_q <= idx_d;
         vld_q <= vld_d;
         ptr_q <= ptr_d;
      end
   end

   assign gnt = gnt_q;
   assign idx = idx_q;
   assign vld = vld_q;

`ifndef SYNTHESIS
   logic             hold_chk_q;
   logic [WIDTH-1:0] hold_gnt_q;

   // Structural invariants on the registered outputs, plus grant stability under stall.
   always @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(gnt_q)) else $error("arb_rr_oht: gnt not onehot0 %b", gnt_q);
         assert (vld_q == |gnt_q) else $error("arb_rr_oht: vld/gnt disagree");
         assert ((vld_q && gnt_q[idx_q]) || (!vld_q && idx_q == '0))
            else $error("arb_rr_oht: idx does not match gnt");
      end
      if (hold_chk_q) begin
         assert (gnt_q == hold_gnt_q) else $error("arb_rr_oht: gnt changed while stalled");
      end
      hold_chk_q <= !rst && vld_q && !rdy;
      hold_gnt_q <= gnt_q;
   end
`endif

endmodule

// File: tb/tb_arb_rr_oht.sv
// Bench for arb_rr_oht: both implementations side by side, a downstream one-hot mux
// with ary[i] = i, and a round-robin reference model kept as plain integers.
module tb_arb_rr_oht;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic [W-1:0] req;

   logic [W-1:0] gnt0, gnt1;
   logic [3:0]   idx0, idx1;
   logic         vld0, vld1;

   int checks   = 0;
   int failures = 0;

   // Reference model: current winner (-1 when idle) and last accepted index.
   int m_cur;
   int m_ptr;

   always #5 clk = ~clk;

   arb_rr_oht #(.WIDTH(W), .IMPLEMENTATION(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt0),
      .idx (idx0),
      .vld (vld0),
      .rdy (rdy)
   );

   arb_rr_oht #(.WIDTH(W), .IMPLEMENTATION(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt1),
      .idx (idx1),
      .vld (vld1),
      .rdy (rdy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream mux_oht with ary[i] = i: OR of the indices of set select bits.
   function automatic logic [31:0] mux_dat(input logic [W-1:0] sel);
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < W; i++) begin
         if (sel[i]) d = d | i;
      end
      return d;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_cur = -1;
         m_ptr = W - 1;
      end else if (m_cur < 0 || rdy) begin
         if (m_cur >= 0) m_ptr = m_cur;
         m_cur = -1;
         for (int k = 1; k <= W; k++) begin
            if (m_cur < 0 && req[(m_ptr + k) % W]) m_cur = (m_ptr + k) % W;
         end
      end
   endtask

   task automatic compare();
      logic [W-1:0] e_gnt;
      int           e_idx;
      e_gnt = '0;
      if (m_cur >= 0) e_gnt[m_cur] = 1'b1;
      e_idx = (m_cur >= 0) ? m_cur : 0;
      check("gnt_impl0", 32'(gnt0), 32'(e_gnt));
      check("idx_impl0", 32'(idx0), e_idx);
      check("vld_impl0", 32'(vld0), 32'(m_cur >= 0));
      check("gnt_impl1", 32'(gnt1), 32'(e_gnt));
      check("idx_impl1", 32'(idx1), e_idx);
      check("vld_impl1", 32'(vld1), 32'(m_cur >= 0));
      check("mux_dat",   mux_dat(gnt0), e_idx);
      check("mux_vld",   32'(|gnt0), 32'(vld0));
   endtask

   // One clock: inputs already stable, model updates at the edge, outputs checked mid-cycle.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic expect_idx(input string tag, input int e);
      check(tag, 32'(idx0), e);
      check({tag, "_vld"}, 32'(vld0), 1);
   endtask

   initial begin
      m_cur = -1;
      m_ptr = W - 1;
      rst   = 1'b1;
      req   = 9'h1FF;
      rdy   = 1'b1;

      // Reset held with all requests pending.
      step();
      check("rst_gnt", 32'(gnt0), 0);
      step();
      check("rst_vld", 32'(vld0), 0);
      rst = 1'b0;
      step();
      check("first_gnt", 32'(gnt0), 32'h001);

      // Full rotation.
      for (int i = 1; i <= 10; i++) begin
         step();
         expect_idx("rotate", i % W);
      end

      // Sparse requests with wrap.
      req = 9'b100000100;
      step(); expect_idx("sparse_a", 2);
      step(); expect_idx("sparse_b", 8);
      step(); expect_idx("sparse_c", 2);
      step(); expect_idx("sparse_d", 8);
      req = 9'b000000101;
      step(); expect_idx("wrap_a", 0);
      step(); expect_idx("wrap_b", 2);

      // Back-pressure holds the grant while requests change.
      req = 9'b000001000;
      step(); expect_idx("bp_grant", 3);
      rdy = 1'b0;
      req = 9'b000100000;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold", 32'(gnt0), 32'h008);
      end
      rdy = 1'b1;
      step();
      check("bp_release", 32'(gnt0), 32'h020);
      expect_idx("bp_idx", 5);

      // Idle cycles keep the pointer.
      req = 9'b000010000;
      step(); expect_idx("idle_pre", 4);
      req = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_vld", 32'(vld0), 0);
      end
      req = 9'h1FF;
      step(); expect_idx("idle_resume", 5);

      // Reset in the middle of a stream.
      step(); expect_idx("stream", 6);
      rst = 1'b1;
      step();
      check("midrst_gnt", 32'(gnt0), 0);
      rst = 1'b0;
      step(); expect_idx("midrst_next", 0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = W'($urandom) & W'($urandom) & W'($urandom);
            default: req = W'($urandom);
         endcase
         rdy = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
